cordic_arbiter: RTL and testbench

Shares one cordic core (clk, rst, en, z in; x, y, done out) between NREQ independent requesters. Round-robin arbitration picks one angle, issues it to the core with a one-cycle en pulse, waits for completion, then returns x/y tagged with the requester id. The block sits between the angle producers and the single cordic instance; nothing else drives the core's en or z.

---
 rtl/cordic_arbiter_if.sv | 30 +++
 rtl/cordic_arbiter.sv | 204 ++++++++++++++++++++
 tb/tb_cordic_arbiter.sv | 299 +++++++++++++++++++++++++++++
 3 files changed

// File: rtl/cordic_arbiter_if.sv
// Request, response and core-side signals of the cordic arbiter.
// The master modport is the arbiter's view; slave is the environment's view.
interface cordic_arbiter_if #(
  parameter int NREQ = 4,
  parameter int W    = 16
);
  logic [NREQ-1:0]   req_valid;
  logic [NREQ-1:0]   req_ready;
  logic [NREQ*W-1:0] req_z;
  logic              rsp_valid;
  logic [NREQ-1:0]   rsp_id;
  logic [W-1:0]      rsp_x;
  logic [W-1:0]      rsp_y;
  logic              rsp_err;
  logic              cor_en;
  logic [W-1:0]      cor_z;
  logic              cor_done;
  logic [W-1:0]      cor_x;
  logic [W-1:0]      cor_y;

  modport master (
    input  req_valid, req_z, cor_done, cor_x, cor_y,
    output req_ready, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err, cor_en, cor_z
  );

  modport slave (
    output req_valid, req_z, cor_done, cor_x, cor_y,
    input  req_ready, rsp_valid, rsp_id, rsp_x, rsp_y, rsp_err, cor_en, cor_z
  );
endinterface

// File: rtl/cordic_arbiter.sv
// Round-robin sharing of one cordic core between NREQ requesters.
// Optional WAIT timeout is enabled by defining CORDIC_ARB_TIMEOUT_EN.
module cordic_arbiter #(
  parameter int NREQ    = 4,
  parameter int W       = 16,
  parameter int TIMEOUT = 63
) (
  input  logic              clk,
  input  logic              rst,
  cordic_arbiter_if.master  bus
);
  localparam int PW = $clog2(NREQ);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    RESP  = 2'd3
  } state_t;

  if (NREQ < 2 || NREQ > 8 || TIMEOUT < 1) begin : g_bad_param
    $error("cordic_arbiter: unsupported parameter set");
  end

  state_t            state_r;
  state_t            next_s;
  logic [PW-1:0]     rr_r;
  logic [PW-1:0]     winner_s;
  logic [PW-1:0]     scan_s [NREQ];
  logic              found_s;
  logic [NREQ-1:0]   onehot_s;
  logic [NREQ-1:0]   ready_s;
  logic [NREQ-1:0]   id_r;
  logic [NREQ-1:0]   rsp_id_r;
  logic [W-1:0]      cor_z_r;
  logic [W-1:0]      rsp_x_r;
  logic [W-1:0]      rsp_y_r;
  logic              cor_en_r;
  logic              rsp_valid_r;
  logic              done_q_r;
  logic              done_edge_s;
  logic              timeout_s;
  logic              accept_s;
  logic              capture_s;
  logic              expire_s;

  // Only a fresh rising edge of done counts, so a level left high from the previous op is ignored
  assign done_edge_s = bus.cor_done & ~done_q_r;

  // First valid requester at or after the rr pointer, wrapping
  always_comb begin
    found_s  = 1'b0;
    winner_s = '0;
    for (int i = 0; i < NREQ; i++) begin
      scan_s[i] = PW'((int'(rr_r) + i) % NREQ);
      winner_s  = (!found_s && bus.req_valid[scan_s[i]]) ? scan_s[i] : winner_s;
      found_s   = found_s | bus.req_valid[scan_s[i]];
    end
    onehot_s = {{(NREQ-1){1'b0}}, 1'b1} << winner_s;
  end

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_r <= IDLE;
    end else begin
      state_r <= next_s;
    end
  end

  // Next-state decode and per-state strobes
  always_comb begin
    next_s    = state_r;
    ready_s   = '0;
    accept_s  = 1'b0;
    capture_s = 1'b0;
    expire_s  = 1'b0;
    case (state_r)
      IDLE: begin
        if (found_s && !rst) begin
          ready_s  = onehot_s;
          accept_s = 1'b1;
          next_s   = ISSUE;
        end else begin
          next_s = IDLE;
        end
      end
      ISSUE: next_s = WAIT;
      WAIT: begin
        if (done_edge_s) begin
          capture_s = 1'b1;
          next_s    = RESP;
        end else if (timeout_s) begin
          expire_s = 1'b1;
          next_s   = RESP;
        end else begin
          next_s = WAIT;
        end
      end
      RESP:    next_s = IDLE;
      default: next_s = IDLE;
    endcase
  end

  // Grant capture: angle, owner and the rotated priority pointer
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cor_z_r <= '0;
      id_r    <= '0;
      rr_r    <= '0;
    end else if (accept_s) begin
      cor_z_r <= bus.req_z[int'(winner_s)*W +: W];
      id_r    <= onehot_s;
      rr_r    <= (winner_s == PW'(NREQ-1)) ? '0 : winner_s + 1'b1;
    end else begin
      cor_z_r <= cor_z_r;
      id_r    <= id_r;
      rr_r    <= rr_r;
    end
  end

  // Strobes are registered so they coincide exactly with the ISSUE and RESP states
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cor_en_r    <= 1'b0;
      rsp_valid_r <= 1'b0;
      done_q_r    <= 1'b0;
    end else begin
      cor_en_r    <= (next_s == ISSUE);
      rsp_valid_r <= (next_s == RESP);
      done_q_r    <= bus.cor_done;
    end
  end

  // Response payload, held until the next response
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_x_r  <= '0;
      rsp_y_r  <= '0;
      rsp_id_r <= '0;
    end else if (capture_s) begin
      rsp_x_r  <= bus.cor_x;
      rsp_y_r  <= bus.cor_y;
      rsp_id_r <= id_r;
    end else if (expire_s) begin
      rsp_x_r  <= '0;
      rsp_y_r  <= '0;
      rsp_id_r <= id_r;
    end else begin
      rsp_x_r  <= rsp_x_r;
      rsp_y_r  <= rsp_y_r;
      rsp_id_r <= rsp_id_r;
    end
  end

`ifdef CORDIC_ARB_TIMEOUT_EN
  localparam int CW = $clog2(TIMEOUT + 1);

  logic [CW-1:0] tmo_cnt_r;
  logic          rsp_err_r;

  // The count equals the number of WAIT cycles already spent
  assign timeout_s = (tmo_cnt_r == CW'(TIMEOUT - 1));

  // WAIT cycle counter, cleared while issuing
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      tmo_cnt_r <= '0;
    end else if (state_r == ISSUE) begin
      tmo_cnt_r <= '0;
    end else if (state_r == WAIT) begin
      tmo_cnt_r <= tmo_cnt_r + 1'b1;
    end else begin
      tmo_cnt_r <= tmo_cnt_r;
    end
  end

  // Error flag travels with the response payload
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rsp_err_r <= 1'b0;
    end else if (capture_s) begin
      rsp_err_r <= 1'b0;
    end else if (expire_s) begin
      rsp_err_r <= 1'b1;
    end else begin
      rsp_err_r <= rsp_err_r;
    end
  end

  assign bus.rsp_err = rsp_err_r;
`else
  assign timeout_s   = 1'b0;
  assign bus.rsp_err = 1'b0;
`endif

  assign bus.req_ready = ready_s;
  assign bus.cor_en    = cor_en_r;
  assign bus.cor_z     = cor_z_r;
  assign bus.rsp_valid = rsp_valid_r;
  assign bus.rsp_id    = rsp_id_r;
  assign bus.rsp_x     = rsp_x_r;
  assign bus.rsp_y     = rsp_y_r;
endmodule

// File: tb/tb_cordic_arbiter.sv
// Directed bench for cordic_arbiter: behavioural core model, scoreboard of
// expected responses pushed at grant time and checked when rsp_valid fires.
module tb_cordic_arbiter;
  localparam int NREQ    = 4;
  localparam int W       = 16;
  localparam int TIMEOUT = 63;

  typedef struct packed {
    logic [NREQ-1:0] id;
    logic [W-1:0]    x;
    logic [W-1:0]    y;
    logic            err;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  cordic_arbiter_if #(.NREQ(NREQ), .W(W)) bus ();
  cordic_arbiter #(.NREQ(NREQ), .W(W), .TIMEOUT(TIMEOUT)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  int   n_chk = 0;
  int   n_fail = 0;
  int   cyc = 0;
  int   rsp_count = 0;
  int   en_count = 0;
  int   rsp_cyc = 0;
  int   en_cyc = 0;
  int   grants[$];
  exp_t sb_q[$];
  logic [W-1:0] grant_z = '0;
  bit   core_hold = 1'b0;
  bit   core_reraise = 1'b0;
  bit   core_dead = 1'b0;
  bit   tmo_mode = 1'b0;
  bit   core_busy = 1'b0;
  int   core_cnt = 0;
  logic [W-1:0] core_zl = '0;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_chk++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Core transfer function: the pi case matches the reference vector, others are arbitrary but distinct
  function automatic logic [2*W-1:0] core_fn(input logic [W-1:0] z);
    if (z == 16'h6488) return {16'hE000, 16'h0000};
    return {~z, z ^ 16'h1234};
  endfunction

  function automatic logic [63:0] outs();
    return {5'd0, bus.req_ready, bus.rsp_valid, bus.rsp_id, bus.rsp_x, bus.rsp_y,
            bus.rsp_err, bus.cor_en, bus.cor_z};
  endfunction

  always @(posedge clk) cyc <= cyc + 1;

  // Behavioural cordic core: 16-cycle latency, optional level-held or missing done
  always @(posedge clk) begin
    if (rst) begin
      core_busy    <= 1'b0;
      bus.cor_done <= 1'b0;
      bus.cor_x    <= '0;
      bus.cor_y    <= '0;
    end else if (bus.cor_en) begin
      core_busy <= 1'b1;
      core_cnt  <= 15;
      core_zl   <= bus.cor_z;
    end else if (core_busy) begin
      if (core_cnt == 0) begin
        core_busy <= 1'b0;
        if (!core_dead) begin
          bus.cor_done             <= 1'b1;
          {bus.cor_x, bus.cor_y}   <= core_fn(core_zl);
        end
      end else begin
        core_cnt <= core_cnt - 1;
      end
    end else if (core_reraise) begin
      bus.cor_done <= 1'b1;
    end else if (!core_hold) begin
      bus.cor_done <= 1'b0;
    end
  end

  // Grant monitor: records order and pushes the expected response
  always @(negedge clk) begin
    if (!rst && |bus.req_ready) begin
      exp_t e;
      int   g;
      g = 0;
      chk("ready_onehot", $countones(bus.req_ready), 1);
      for (int i = 0; i < NREQ; i++) if (bus.req_ready[i]) g = i;
      grants.push_back(g);
      grant_z = bus.req_z[g*W +: W];
      e.id  = bus.req_ready;
      {e.x, e.y} = tmo_mode ? 32'h0 : core_fn(grant_z);
      e.err = tmo_mode;
      sb_q.push_back(e);
    end
  end

  // Issue and response monitor
  always @(negedge clk) begin
    if (!rst && bus.cor_en) begin
      en_count++;
      en_cyc = cyc;
      chk("cor_z", bus.cor_z, grant_z);
    end
    if (!rst && bus.rsp_valid) begin
      rsp_count++;
      rsp_cyc = cyc;
      if (sb_q.size() == 0) begin
        chk("rsp_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = sb_q.pop_front();
        chk("rsp_id", bus.rsp_id, e.id);
        chk("rsp_x", bus.rsp_x, e.x);
        chk("rsp_y", bus.rsp_y, e.y);
        chk("rsp_err", bus.rsp_err, e.err);
      end
    end
  end

  task automatic set_req(input int i, input logic [W-1:0] z);
    bus.req_z[i*W +: W] = z;
    bus.req_valid[i]    = 1'b1;
  endtask

  // Drop each requester's valid once its ready has been seen
  task automatic serve(input int budget);
    logic [NREQ-1:0] rdy;
    for (int c = 0; c < budget && bus.req_valid != '0; c++) begin
      @(negedge clk);
      rdy = bus.req_ready;
      @(posedge clk);
      #1;
      bus.req_valid = bus.req_valid & ~rdy;
    end
    chk("serve_done", bus.req_valid, '0);
  endtask

  task automatic wait_rsp(input int target, input int budget);
    for (int c = 0; c < budget && rsp_count < target; c++) begin
      @(posedge clk);
      #1;
    end
    chk("rsp_arrived", rsp_count >= target, 1);
  endtask

  task automatic pulse_reset();
    @(posedge clk);
    #1;
    rst = 1'b1;
    bus.req_valid = '0;
    sb_q.delete();
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    int c0;
    int e0;
    int exp_rr[5] = '{0, 1, 2, 3, 0};
    int exp_fair[4] = '{1, 3, 1, 3};

    bus.req_valid = '0;
    bus.req_z     = '0;
    repeat (3) @(posedge clk);
    #1;
    chk("reset_outputs", outs(), 64'h0);
    rst = 1'b0;
    @(posedge clk);
    #1;
    chk("idle_outputs", outs(), 64'h0);

    // Single request
    set_req(0, 16'h6488);
    serve(10);
    wait_rsp(1, 60);
    chk("single_en_pulses", en_count, 1);
    chk("single_grants", grants.size(), 1);
    chk("rsp_valid_one_cycle", bus.rsp_valid, 0);
    chk("rsp_x_hold", bus.rsp_x, 16'hE000);
    chk("rsp_id_hold", bus.rsp_id, 4'b0001);

    // Round robin from a fresh pointer
    pulse_reset();
    grants.delete();
    c0 = rsp_count;
    set_req(0, 16'h6488);
    set_req(1, 16'h3244);
    set_req(2, 16'h1922);
    set_req(3, 16'h0000);
    serve(200);
    set_req(0, 16'h6488);
    serve(40);
    wait_rsp(c0 + 5, 100);
    chk("rr_grant_count", grants.size(), 5);
    for (int k = 0; k < 5; k++)
      chk($sformatf("rr_order_%0d", k), (k < grants.size()) ? grants[k] : -1, exp_rr[k]);

    // Fairness with two continuously valid requesters
    grants.delete();
    c0 = rsp_count;
    set_req(1, 16'h1111);
    set_req(3, 16'h3333);
    for (int c = 0; c < 200 && grants.size() < 4; c++) begin
      @(posedge clk);
      #1;
    end
    bus.req_valid = '0;
    wait_rsp(c0 + 4, 60);
    chk("fair_grant_count", grants.size(), 4);
    for (int k = 0; k < 4; k++)
      chk($sformatf("fair_order_%0d", k), (k < grants.size()) ? grants[k] : -1, exp_fair[k]);

    // Level-held done must not complete the following operation
    core_hold = 1'b1;
    c0 = rsp_count;
    set_req(2, 16'h1922);
    serve(10);
    wait_rsp(c0 + 1, 60);
    c0 = rsp_count;
    set_req(0, 16'h3244);
    serve(10);
    repeat (30) @(posedge clk);
    #1;
    chk("no_rsp_on_level_done", rsp_count, c0);
    core_hold = 1'b0;
    @(posedge clk);
    #1;
    @(posedge clk);
    #1;
    chk("no_rsp_on_done_fall", rsp_count, c0);
    core_reraise = 1'b1;
    @(posedge clk);
    #1;
    core_reraise = 1'b0;
    wait_rsp(c0 + 1, 10);

    // Reset in the middle of WAIT drops the op; the held request is re-granted
    grants.delete();
    e0 = en_count;
    set_req(2, 16'h1922);
    for (int c = 0; c < 20 && en_count == e0; c++) begin
      @(posedge clk);
      #1;
    end
    chk("mid_issue_seen", en_count, e0 + 1);
    repeat (5) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("reset_mid_outputs", outs(), 64'h0);
    sb_q.delete();
    c0 = rsp_count;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("no_rsp_after_reset", rsp_count, c0);
    serve(20);
    wait_rsp(c0 + 1, 60);
    chk("regrant_count", grants.size(), 2);
    chk("regrant_id", (grants.size() > 1) ? grants[1] : -1, 2);

    // Core that never completes
    pulse_reset();
    tmo_mode  = 1'b1;
    core_dead = 1'b1;
    c0 = rsp_count;
    set_req(0, 16'h6488);
    serve(10);
`ifdef CORDIC_ARB_TIMEOUT_EN
    wait_rsp(c0 + 1, 120);
    chk("tmo_latency", rsp_cyc - en_cyc, TIMEOUT + 1);
`else
    repeat (200) @(posedge clk);
    #1;
    chk("no_rsp_without_timeout", rsp_count, c0);
    pulse_reset();
`endif
    tmo_mode  = 1'b0;
    core_dead = 1'b0;
    chk("scoreboard_empty", sb_q.size(), 0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
